// File: rtl/rnd_pkg.sv
// Shared widths and word type for the xoroshiro128+ generator and its output buffer.
package rnd_pkg;

  localparam int RND_W  = 64;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] rnd_word_t;

endpackage

// File: rtl/rnd_word_fifo.sv
// Splits 64-bit PRNG results into two 32-bit words (low half first) and serves
// them through a first-word-fall-through FIFO, one word per cycle.
//
// Both ports use strict valid/ready: a transfer happens in a cycle where valid
// and ready are both 1 at the rising clock edge. Nothing is consumed otherwise.
// in_data is sampled only on a push. out_data is stable while out_valid is high
// and no pop happens.
module rnd_word_fifo
  import rnd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [RND_W-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WORD_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PUSH_MAX = CW'(DEPTH - 2);

  rnd_word_t     mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  // A push needs room for both halves; only the registered count is used, so
  // out_ready never reaches in_ready combinationally.
  assign in_ready  = !reset && (count_q <= PUSH_MAX);
  assign out_valid = (count_q != '0);
  assign out_data  = mem[rptr];
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr]           <= in_data[WORD_W-1:0];
      mem[wptr + AW'(1)]  <= in_data[RND_W-1:WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(2);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(2);
        2'b01:   count_q <= count_q - CW'(1);
        2'b11:   count_q <= count_q + CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/rnd_word_fifo.md
# rnd_word_fifo

Output buffer stage placed directly after the xoroshiro128+ generator. It accepts 64-bit PRNG results over a valid/ready handshake and splits each one into two 32-bit words, low half first. It buffers the words in a small FIFO and serves them one per cycle to the consumer over a second valid/ready handshake. The generator ties `in_valid` high and uses `in_ready` as its step enable, so no random value is ever dropped or repeated.

## Interface
- `DEPTH`, default 8: FIFO capacity in 32-bit words. Must be a power of two and ≥ 4.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  64  PRNG result.
- `in_valid`  in  1  `in_data` holds a value.
- `in_ready`  out  1  block will accept `in_data` this cycle.
- `out_data`  out  32  current head-of-FIFO word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer takes `out_data` this cycle.
- `count`  out  $clog2(DEPTH)+1  number of words currently stored.

## Operation
- Storage: DEPTH × 32-bit array.
  - Write pointer `wptr` and read pointer `rptr` are each $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH with natural overflow.
  - Registered `count` runs from 0 to DEPTH.
- Push: occurs when `in_valid && in_ready`.
  - `mem[wptr] <= in_data[31:0]`.
  - `mem[wptr+1] <= in_data[63:32]`.
  - `wptr <= wptr+2`.
- Pop: occurs when `out_valid && out_ready`; `rptr <= rptr+1`.
- Count update:
  - push only: +2
  - pop only: −1
  - push and pop together: +1
  - neither: unchanged
- `in_ready = !reset && (DEPTH − count ≥ 2)`. It is derived from the registered count only; a same-cycle pop gives no lookahead.
- `out_valid = (count != 0)`.
- `out_data = mem[rptr]`. The FIFO is first-word-fall-through. `out_data` is don't-care while `out_valid` is 0.
- Ordering: words leave in push order, and each push yields its low half before its high half.
- Handshake rules:
  - `in_data` is sampled only on a push.
  - With `out_valid` high and no pop, `out_data` holds stable.
  - The consumer may hold `out_ready` high permanently.
- Full and odd-count cases:
  - At count = DEPTH, or DEPTH−1, `in_ready` is 0. No partial (single-half) push is ever made.
  - At count = 0, `out_ready` has no effect.
- Reset (synchronous, any cycle, including mid-stream):
  - `wptr`, `rptr` and `count` go to 0.
  - Array contents are not cleared, but they are unreachable.
  - No word written before reset ever appears on the output after reset.
- Reset values: `count` = 0, `out_valid` = 0, `in_ready` = 0 while `reset` is high, then 1 in the first cycle after deassertion.

## Timing
- Push-to-output latency: a push in cycle N makes the low half visible on `out_data` with `out_valid` = 1 in cycle N+1. The high half follows after that word is popped.
- Throughput on the output side: one word per cycle sustained.
- Throughput on the input side: at most one push per cycle, limited by `in_ready`.
- Steady state with `in_valid` = `out_ready` = 1:
  - `out_valid` stays high continuously from the first push.
  - `count` climbs to DEPTH−1 or DEPTH.
  - `in_ready` then settles to a 1-of-2 duty cycle.
- No combinational path from `out_ready` to `in_ready`.
- The only input-to-output combinational path is `reset` → `in_ready`.

## Structure
- Shared package `rnd_pkg`:
  - `RND_W` = 64
  - `WORD_W` = 32
  - typedef `rnd_word_t` = logic [WORD_W-1:0]
- The PRNG core and this block both import `rnd_pkg`.
- Single module, with no sub-module. The array, pointers and counter stay inline, because the dual-word write port is specific to this block.

## Test plan
- Single push, in_data = 64'h0123_4567_89AB_CDEF, out_ready = 1:
  - cycle N+1 gives `out_data` = 32'h89AB_CDEF;
  - cycle N+2 gives 32'h0123_4567;
  - then `out_valid` = 0 and `count` = 0.
- Fill with out_ready = 0, DEPTH = 8, in_valid = 1:
  - exactly 4 pushes are accepted, then `in_ready` = 0 and `count` = 8;
  - releasing `out_ready` drains 8 words in order with no gaps.
- Odd count: from count = 8, pop one word → `count` = 7, and `in_ready` stays 0. Pop one more → `count` = 6, and `in_ready` = 1 on the next cycle.
- Simultaneous push and pop at `count` = 6 → `count` = 7 next cycle, with the head word advanced by one.
- Reset mid-operation: with count = 5, assert `reset` for one cycle. Next cycle: `count` = 0 and `out_valid` = 0. The next push's low half is the first word out, and no stale word is ever emitted.
- Wrap and streaming: push 20 incrementing values `{i+1, i}` with a random `out_ready` pattern. The scoreboard checks strict word order across pointer wrap, never a value skipped or duplicated, and `count` always ≤ DEPTH.
